// File: rtl/pc_gen.sv
// pc_gen: program counter with BOOT/RUN/TRAP sequencing; in clk_i, rst_n_i, stall_i, trap_i, PC_src_i, branch_PC_i, jalr_PC_i; out PC_o, inc_PC_o, valid_o, misaligned_o, misaligned_addr_o
module pc_gen #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  stall_i,
    input  logic                  trap_i,
    input  logic [1:0]            PC_src_i,
    input  logic [DATA_WIDTH-1:0] branch_PC_i,
    input  logic [DATA_WIDTH-1:0] jalr_PC_i,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] inc_PC_o,
    output logic                  valid_o,
    output logic                  misaligned_o,
    output logic [DATA_WIDTH-1:0] misaligned_addr_o
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] pc_n, addr_n, cand;
    logic mis_n, cand_mis;
    assign inc_PC_o = PC_o + DATA_WIDTH'(4);
    assign valid_o = state == RUN;
    assign cand = PC_src_i == 2'b01 ? branch_PC_i :
                  PC_src_i == 2'b10 ? (jalr_PC_i & ~DATA_WIDTH'(1)) : inc_PC_o;
    assign cand_mis = cand[1:0] != 2'b00;
    always_comb begin
        state_n = RUN;
        pc_n = PC_o;
        addr_n = misaligned_addr_o;
        mis_n = 1'b0;
        if (state == RUN) begin
            if (trap_i) begin
                pc_n = TRAP_VECTOR;
                state_n = TRAP;
            end else if (!stall_i) begin
                pc_n = cand_mis ? TRAP_VECTOR : cand;
                mis_n = cand_mis;
                addr_n = cand_mis ? cand : misaligned_addr_o;
                state_n = cand_mis ? TRAP : RUN;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= BOOT;
            PC_o <= RESET_VECTOR;
            misaligned_o <= 1'b0;
            misaligned_addr_o <= '0;
        end else begin
            state <= state_n;
            PC_o <= pc_n;
            misaligned_o <= mis_n;
            misaligned_addr_o <= addr_n;
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized scoreboard bench for pc_gen against a behavioural model
module tb_pc_gen;
    localparam longint MOD = 64'h1_0000_0000;
    localparam longint TV = 64'h100;
    localparam longint RV = 0;
    localparam int M_BOOT = 0, M_RUN = 1, M_TRAP = 2;
    typedef struct {
        longint pc;
        bit valid;
        bit mis;
        longint addr;
    } exp_t;
    logic clk = 0;
    logic rst_n = 0, stall = 0, trap = 0;
    logic [1:0] src = 0;
    logic [31:0] br = 0, jr = 0;
    logic [31:0] pc, inc_pc, mis_addr;
    logic valid, mis;
    exp_t q[$];
    int total = 0, bad = 0;
    int m_mode = M_BOOT;
    longint m_pc = 0, m_addr = 0;
    bit m_mis = 0;
    always #5 clk = ~clk;
    pc_gen dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .trap_i(trap), .PC_src_i(src),
        .branch_PC_i(br), .jalr_PC_i(jr), .PC_o(pc), .inc_PC_o(inc_pc), .valid_o(valid),
        .misaligned_o(mis), .misaligned_addr_o(mis_addr)
    );
    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask
    task automatic model();
        longint tgt;
        if (!rst_n) begin
            m_mode = M_BOOT; m_pc = RV; m_mis = 0; m_addr = 0;
            return;
        end
        m_mis = 0;
        if (m_mode != M_RUN) begin
            m_mode = M_RUN;
            return;
        end
        if (src == 2'b01) tgt = br;
        else if (src == 2'b10) tgt = jr - (jr % 2);
        else tgt = (m_pc + 4) % MOD;
        if (trap) begin
            m_pc = TV; m_mode = M_TRAP;
        end else if (!stall) begin
            if (tgt % 4 != 0) begin
                m_pc = TV; m_mis = 1; m_addr = tgt; m_mode = M_TRAP;
            end else m_pc = tgt;
        end
    endtask
    task automatic step(input bit r, input bit s, input bit t, input logic [1:0] c,
                        input logic [31:0] b, input logic [31:0] j);
        exp_t e;
        @(negedge clk);
        rst_n = r; stall = s; trap = t; src = c; br = b; jr = j;
        model();
        e.pc = m_pc; e.valid = m_mode == M_RUN; e.mis = m_mis; e.addr = m_addr;
        q.push_back(e);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("inc_pc", inc_pc, (e.pc + 4) % MOD);
                chk("valid", valid, e.valid);
                chk("misaligned", mis, e.mis);
                chk("misaligned_addr", mis_addr, e.addr);
            end
        end
    end
    initial begin
        int r;
        step(0, 1, 1, 2'b01, 32'h42, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2'b01, 32'h42, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2'b01, 32'h40, 0);
        step(1, 0, 0, 2'b10, 0, 32'h81);
        step(1, 0, 0, 2'b01, 32'h40, 0);
        step(1, 0, 0, 2'b01, 32'h42, 0);
        step(1, 0, 0, 2'b01, 32'h42, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2'b01, 32'h20, 0);
        repeat (3) step(1, 1, 0, 2'b01, 32'h60, 0);
        step(1, 0, 0, 2'b01, 32'h60, 0);
        step(1, 1, 1, 2'b01, 32'h62, 0);
        step(1, 1, 1, 2'b01, 32'h62, 0);
        step(1, 0, 0, 2'b11, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2'b01, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 2'b00, 0, 0);
        step(1, 0, 0, 2'b10, 0, 32'h7);
        step(1, 1, 0, 2'b00, 0, 0);
        step(1, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99);
            step(r != 0, $urandom_range(9) == 0, $urandom_range(19) == 0,
                 2'($urandom_range(3)),
                 $urandom_range(4) == 0 ? $urandom() : $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(4) == 0 ? $urandom() : $urandom() & 32'hFFFF_FFFD);
        end
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
